// File: rtl/jk_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// jk_mod_counter_pkg
// Shared definitions for the JK-based modulo-N counter:
//   CNT_UP / CNT_DN : values of the direction input
//   next_count()    : next count value for a given current count, direction,
//                     modulus and saturation flag. Operands are carried in
//                     32 bits; callers truncate the result to their width.
// -----------------------------------------------------------------------------
package jk_mod_counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Next count value. Any value above modulus-1 is an illegal state and
  // recovers to zero regardless of direction or saturation.
  function automatic logic [31:0] next_count(
    input logic [31:0] cur,
    input logic        dir,
    input logic [31:0] modulus,
    input logic        sat
  );
    logic [31:0] top_v;
    logic [31:0] nxt;
    top_v = modulus - 32'd1;
    if (cur > top_v) begin
      nxt = 32'd0;
    end else if (dir == CNT_UP) begin
      if (cur == top_v) begin
        nxt = sat ? cur : 32'd0;
      end else begin
        nxt = cur + 32'd1;
      end
    end else begin
      if (cur == 32'd0) begin
        nxt = sat ? cur : top_v;
      end else begin
        nxt = cur - 32'd1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/jk_mod_counter_jk_ff_cell.sv
// -----------------------------------------------------------------------------
// jk_ff_cell
// Single JK flip-flop built from a D register with D = J&~Q | ~K&Q.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear (Q -> 0)
//   j, k  : excitation inputs (00 hold, 10 set, 01 reset, 11 toggle)
//   q     : stored bit
// -----------------------------------------------------------------------------
module jk_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK storage bit with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_counter
// Synchronous modulo-MODULUS up/down counter. All state is held in WIDTH
// jk_ff_cell instances; this level only produces their J/K excitation, the
// load clamp and the terminal-count flag.
//
// Parameters:
//   WIDTH   : counter width in bits (>= 2)
//   MODULUS : count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : count enable
//   up    : direction, 1 = increment, 0 = decrement
//   load  : synchronous parallel load, has priority over en
//   din   : load value, clamped to MODULUS-1
//   q     : current count (direct JK cell outputs)
//   tc    : terminal count, combinational: en & (up ? q==MODULUS-1 : q==0)
// Configuration:
//   JK_CNT_SAT_EN : when defined the counter saturates at the limits instead
//                   of wrapping.
// -----------------------------------------------------------------------------
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

`ifdef JK_CNT_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 32'd1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] d_eff_s;
  logic [WIDTH-1:0] cnt_next_s;
  logic [WIDTH-1:0] toggle_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;

  // Load clamp, next count and per-bit J/K excitation.
  // Load drives set/reset (J = ~K) so no toggle is ever applied while loading;
  // counting toggles exactly the bits that differ from the target value.
  always_comb begin
    d_eff_s    = (din > MAX_VAL) ? MAX_VAL : din;
    cnt_next_s = WIDTH'(next_count(32'(q), up, 32'(MODULUS), SAT_EN));
    toggle_s   = cnt_next_s ^ q;
    j_s        = {WIDTH{1'b0}};
    k_s        = {WIDTH{1'b0}};
    if (load) begin
      j_s = d_eff_s;
      k_s = ~d_eff_s;
    end else if (en) begin
      j_s = toggle_s;
      k_s = toggle_s;
    end else begin
      j_s = {WIDTH{1'b0}};
      k_s = {WIDTH{1'b0}};
    end
  end

  // Terminal count: flags the state just before a wrap (or the limit when
  // saturating) in the currently selected direction.
  assign tc = en & ((up == CNT_UP) ? (q == MAX_VAL) : (q == ZERO_VAL));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
      jk_ff_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (j_s[gi]),
        .k     (k_s[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_jk_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_mod_counter
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10). A behavioural
// model of the count (plain modulo arithmetic on an int) predicts q and tc.
// Honours JK_CNT_SAT_EN in the model so either build can be checked.
// -----------------------------------------------------------------------------
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

`ifdef JK_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic         tc;

  int checks;
  int fails;
  int mq;  // model count

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .up    (up),
    .load  (load),
    .din   (din),
    .q     (q),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one clock edge with reset released.
  function automatic int m_next(int cur, bit e, bit u, bit l, int d);
    if (l) return (d < M) ? d : M - 1;
    if (!e) return cur;
    if (cur >= M) return 0;
    if (SAT && u && cur == M - 1) return cur;
    if (SAT && !u && cur == 0) return cur;
    if (u) return (cur + 1) % M;
    return (cur + M - 1) % M;
  endfunction

  function automatic bit m_tc(int cur, bit e, bit u);
    return e && (u ? (cur == M - 1) : (cur == 0));
  endfunction

  // Apply one rising edge and advance the model; returns 1 ns after the edge.
  task automatic tick();
    int nxt;
    nxt = m_next(mq, en, up, load, int'(din));
    @(posedge clk);
    mq = nxt;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
    mq = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q !== W'(0) || tc !== 1'b0) begin
      fails++; $display("FAIL reset_state: q=%0d tc=%0b, required q=0 tc=0", q, tc);
    end
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    repeat (7) tick();
    checks++;
    if (q !== W'(mq)) begin
      fails++; $display("FAIL count_to_7: q=%0d, required %0d", q, mq);
    end
    // Asynchronous clear between edges.
    rst_n = 1'b0; mq = 0; up = 1'b0;
    #1;
    checks++;
    if (q !== W'(0)) begin
      fails++; $display("FAIL async_clear: q=%0d, required 0", q);
    end
    checks++;
    if (tc !== 1'b1) begin
      fails++; $display("FAIL reset_tc_down: tc=%0b, required 1", tc);
    end
    // Edge while reset held has no effect.
    @(posedge clk); #1;
    checks++;
    if (q !== W'(0)) begin
      fails++; $display("FAIL edge_in_reset: q=%0d, required 0", q);
    end
    rst_n = 1'b1; up = 1'b1;
    tick();
    checks++;
    if (q !== W'(1)) begin
      fails++; $display("FAIL first_edge_after_reset: q=%0d, required 1", q);
    end
  endtask

  task automatic test_up_wrap();
    load = 1'b1; din = W'(0); tick(); load = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (tc !== m_tc(mq, en, up)) begin
        fails++; $display("FAIL up_wrap_tc[%0d]: q=%0d tc=%0b, required %0b", i, q, tc, m_tc(mq, en, up));
      end
      tick();
      checks++;
      if (q !== W'(mq)) begin
        fails++; $display("FAIL up_wrap_q[%0d]: q=%0d, required %0d", i, q, mq);
      end
    end
  endtask

  task automatic test_down_wrap();
    en = 1'b0; load = 1'b1; din = W'(2); tick(); load = 1'b0;
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (tc !== m_tc(mq, en, up)) begin
        fails++; $display("FAIL down_wrap_tc[%0d]: q=%0d tc=%0b, required %0b", i, q, tc, m_tc(mq, en, up));
      end
      tick();
      checks++;
      if (q !== W'(mq)) begin
        fails++; $display("FAIL down_wrap_q[%0d]: q=%0d, required %0d", i, q, mq);
      end
    end
  endtask

  task automatic test_load();
    en = 1'b1; up = 1'b1; load = 1'b1; din = W'(5);
    tick();
    checks++;
    if (q !== W'(5)) begin
      fails++; $display("FAIL load_priority: q=%0d, required 5", q);
    end
    din = W'(13);
    tick();
    checks++;
    if (q !== W'(9)) begin
      fails++; $display("FAIL load_clamp: q=%0d, required 9", q);
    end
    load = 1'b0;
  endtask

  task automatic test_hold();
    en = 1'b0; load = 1'b1; din = W'(4); tick(); load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = ~up;
      tick();
      checks++;
      if (q !== W'(4) || tc !== 1'b0) begin
        fails++; $display("FAIL hold[%0d]: q=%0d tc=%0b, required q=4 tc=0", i, q, tc);
      end
    end
  endtask

  task automatic test_limits();
    en = 1'b0; load = 1'b1; din = W'(8); tick(); load = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== W'(mq) || tc !== m_tc(mq, en, up)) begin
        fails++; $display("FAIL limit_up[%0d]: q=%0d tc=%0b, required q=%0d tc=%0b", i, q, tc, mq, m_tc(mq, en, up));
      end
    end
    en = 1'b0; load = 1'b1; din = W'(1); tick(); load = 1'b0;
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== W'(mq) || tc !== m_tc(mq, en, up)) begin
        fails++; $display("FAIL limit_down[%0d]: q=%0d tc=%0b, required q=%0d tc=%0b", i, q, tc, mq, m_tc(mq, en, up));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1);
      load = ($urandom_range(0, 7) == 0);
      din  = W'($urandom_range(0, 15));
      #1;
      checks++;
      if (tc !== m_tc(mq, en, up)) begin
        fails++; $display("FAIL rand_tc[%0d]: q=%0d tc=%0b, required %0b", i, q, tc, m_tc(mq, en, up));
      end
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0; mq = 0;
        #1;
        checks++;
        if (q !== W'(0)) begin
          fails++; $display("FAIL rand_reset[%0d]: q=%0d, required 0", i, q);
        end
        rst_n = 1'b1;
      end
      tick();
      checks++;
      if (q !== W'(mq)) begin
        fails++; $display("FAIL rand_q[%0d]: q=%0d, required %0d", i, q, mq);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold();
    test_limits();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter whose state bits are held exclusively in JK flip-flop cells; all next-state behaviour is expressed as per-bit J/K excitation. It is the consumer stage for the team's D-to-JK flip-flop conversion: that cell's D = J&~Q | ~K&Q equation is the storage element, and this block generates the J/K drive. It feeds downstream timer/divider logic through its count and terminal-count outputs.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- MODULUS, 10, count range 0..MODULUS-1 (2 ≤ MODULUS ≤ 2^WIDTH)

- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- EN  input  1  count enable
- UP  input  1  direction: 1 = increment, 0 = decrement
- LOAD  input  1  synchronous parallel load
- DIN  input  WIDTH  load value
- Q  output  WIDTH  current count, direct JK cell outputs
- TC  output  1  terminal count, combinational

## Operation
- Reset: RST_N low forces every cell Q=0 immediately, regardless of CLK; TC follows from Q=0 (high only if EN=1 and UP=0).
- Priority per edge: LOAD > EN > hold.
- LOAD=1: per bit J=D_eff[i], K=~D_eff[i]; D_eff = DIN if DIN < MODULUS, else MODULUS-1.
- EN=1, LOAD=0, UP=1: Q → Q+1; at Q=MODULUS-1, Q → 0 (wrap).
- EN=1, LOAD=0, UP=0: Q → Q-1; at Q=0, Q → MODULUS-1 (wrap).
- Hold (EN=0, LOAD=0): J=K=0 on every bit.
- Count excitation: for each bit compute target next value N[i]; drive J=K=1 where N[i]≠Q[i], J=K=0 otherwise. Load uses set/reset (J≠K) encoding. J=K=1 never applied during load.
- TC = EN & (UP ? Q==MODULUS-1 : Q==0); asserted in the cycle before the wrapping edge.
- Q outside range (only reachable if MODULUS≠2^WIDTH and illegal state forced): next count edge goes to 0 in either direction.
- Arithmetic in WIDTH bits; comparisons against MODULUS-1 use WIDTH-bit constants.

## Timing
- Q changes only on rising CLK (or asynchronously on RST_N fall); one-cycle latency from LOAD/EN sample to new Q.
- Reset release: first edge with RST_N high may count/load normally; no extra idle cycle.
- RST_N asserted mid-count: Q cleared at once; an edge coincident with RST_N low has no effect.
- LOAD and EN high together: load wins, no count that cycle.
- UP change takes effect on the next edge; TC responds combinationally in the same cycle.

## Configuration
- JK_CNT_SAT_EN defined: saturating mode. Up at MODULUS-1 holds (J=K=0 all bits); down at 0 holds. TC still asserts at the limits.
- Undefined: wrap-around behaviour as in Operation.

## Structure
- Shared package: direction constants (CNT_UP=1, CNT_DN=0) and a function computing next count given Q, UP, MODULUS, saturation flag.
- Sub-module jk_ff_cell: one JK flip-flop (D = J&~Q | ~K&Q) with CLK and RST_N async clear; instantiated WIDTH times via generate. Counter top contains only excitation logic, load clamp and TC.

## Test plan
- Reset: RST_N=0 mid-count at Q=7 → Q=0 immediately before next edge; release, EN=1 UP=1 → Q=1 after one edge.
- Up wrap (WIDTH=4, MODULUS=10): EN=1 UP=1 from 0 for 12 edges → 1..9,0,1,2; TC=1 only while Q=9.
- Down wrap: LOAD DIN=2, then UP=0 EN=1 for 4 edges → 1,0,9,8; TC=1 only while Q=0.
- Load priority/clamp: LOAD=1 EN=1 DIN=5 → Q=5 (no count); DIN=13 → Q=9.
- Hold: EN=0 LOAD=0 for 5 edges at Q=4 → Q stays 4, TC=0; toggling UP changes nothing.
- Saturation (JK_CNT_SAT_EN): count up from 8 for 3 edges → 9,9,9; down from 1 → 0,0.
